// File: rtl/veggie_round_ctrl.sv
// veggie_round_ctrl: per-frame scheduler for the veggie playfield. Owns the
// veggie slots (spawn, parabolic motion, slicing, retirement) and the round
// bookkeeping (score, lives, IDLE/PLAY/OVER). Every update is taken on the
// frame_done_in cycle so the sprites see a stable picture for a whole frame.
module veggie_round_ctrl #(
  parameter int NUM_SLOTS    = 4,
  parameter int SPAWN_PERIOD = 90,
  parameter int START_LIVES  = 3,
  parameter int GRAVITY      = 1,
  parameter int HIT_RADIUS   = 64,
  parameter int EXIT_Y       = 832
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   frame_done_in,
  input  logic                   start_in,
  input  logic [15:0]            random_in,
  input  logic [10:0]            katana_x,
  input  logic [9:0]             katana_y,
  output logic [NUM_SLOTS-1:0]   slot_active_out,
  output logic [NUM_SLOTS-1:0]   slot_split_out,
  output logic [11*NUM_SLOTS-1:0] slot_x_out,
  output logic [10*NUM_SLOTS-1:0] slot_y_out,
  output logic [15:0]            score_out,
  output logic [3:0]             lives_out,
  output logic [1:0]             state_out
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_PLAY = 2'b01;
  localparam logic [1:0] ST_OVER = 2'b10;

  localparam int TW = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(SPAWN_PERIOD - 1);

  logic [1:0]           state, state_n;
  logic [15:0]          score, score_n;
  logic [3:0]           lives, lives_n, lives_left;
  logic [TW-1:0]        timer, timer_n;
  logic [NUM_SLOTS-1:0] active, active_n, split, split_n;
  logic signed [11:0]   pos_x [NUM_SLOTS];
  logic signed [11:0]   pos_y [NUM_SLOTS];
  logic signed [11:0]   vel_x [NUM_SLOTS];
  logic signed [11:0]   vel_y [NUM_SLOTS];
  logic signed [11:0]   pos_x_n [NUM_SLOTS];
  logic signed [11:0]   pos_y_n [NUM_SLOTS];
  logic signed [11:0]   vel_x_n [NUM_SLOTS];
  logic signed [11:0]   vel_y_n [NUM_SLOTS];
  logic signed [11:0]   move_x [NUM_SLOTS];
  logic signed [11:0]   move_y [NUM_SLOTS];
  logic signed [11:0]   move_vx [NUM_SLOTS];
  logic signed [11:0]   move_vy [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] hit, spawn_sel;
  logic                 any_free;
  logic [7:0]           hit_cnt, unsplit_cnt;
  logic [16:0]          score_sum;
  logic                 unused_random;

  assign unused_random = ^{random_in[15], random_in[12]};

  // True when the katana centre lies within the hit half-box along one axis.
  function automatic logic near(input logic [10:0] k, input logic signed [11:0] p);
    logic signed [12:0] d;
    d = $signed({2'b00, k}) - $signed({p[11], p});
    if (d < 0) d = -d;
    return (d <= 13'(HIT_RADIUS));
  endfunction

  // Per-slot hit detection, candidate motion with wall bounce, and the spawn target.
  always_comb begin
    hit       = '0;
    hit_cnt   = '0;
    spawn_sel = '0;
    any_free  = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      hit[i] = active[i] & ~split[i] & near(katana_x, pos_x[i]) &
               near({1'b0, katana_y}, pos_y[i]);
      hit_cnt    = hit_cnt + {7'b0, hit[i]};
      move_y[i]  = pos_y[i] + vel_y[i];
      move_vy[i] = vel_y[i] + 12'(GRAVITY);
      move_x[i]  = pos_x[i] + vel_x[i];
      move_vx[i] = vel_x[i];
      if (move_x[i] < 0) begin
        move_x[i]  = 12'sd0;
        move_vx[i] = -vel_x[i];
      end else if (move_x[i] > 12'sd1023) begin
        move_x[i]  = 12'sd1023;
        move_vx[i] = -vel_x[i];
      end
      if (!active[i] && !any_free) begin
        any_free     = 1'b1;
        spawn_sel[i] = 1'b1;
      end
    end
  end

  // Round FSM and the ordered frame update: hit, move, exit, spawn.
  always_comb begin
    state_n     = state;
    score_n     = score;
    lives_n     = lives;
    timer_n     = timer;
    active_n    = active;
    split_n     = split;
    pos_x_n     = pos_x;
    pos_y_n     = pos_y;
    vel_x_n     = vel_x;
    vel_y_n     = vel_y;
    unsplit_cnt = '0;
    lives_left  = lives;
    score_sum   = {1'b0, score} + {9'b0, hit_cnt};
    if (state != ST_PLAY && start_in) begin
      state_n  = ST_PLAY;
      score_n  = '0;
      lives_n  = 4'(START_LIVES);
      timer_n  = '0;
      active_n = '0;
      split_n  = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        pos_x_n[i] = '0;
        pos_y_n[i] = '0;
        vel_x_n[i] = '0;
        vel_y_n[i] = '0;
      end
    end else if (state == ST_PLAY && frame_done_in) begin
      score_n = score_sum[16] ? 16'hFFFF : score_sum[15:0];
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (active[i]) begin
          pos_x_n[i] = move_x[i];
          vel_x_n[i] = move_vx[i];
          pos_y_n[i] = move_y[i];
          vel_y_n[i] = move_vy[i];
          split_n[i] = split[i] | hit[i];
          if (move_y[i] >= 12'(EXIT_Y) && vel_y[i] > 0) begin
            if (!(split[i] | hit[i])) unsplit_cnt = unsplit_cnt + 8'd1;
            active_n[i] = 1'b0;
            split_n[i]  = 1'b0;
            pos_x_n[i]  = '0;
            pos_y_n[i]  = '0;
            vel_x_n[i]  = '0;
            vel_y_n[i]  = '0;
          end
        end
      end
      lives_left = ({4'b0, lives} > unsplit_cnt) ? lives - unsplit_cnt[3:0] : 4'd0;
      lives_n    = lives_left;
      if (lives_left == 4'd0) begin
        state_n  = ST_OVER;
        active_n = '0;
        split_n  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
          pos_x_n[i] = '0;
          pos_y_n[i] = '0;
          vel_x_n[i] = '0;
          vel_y_n[i] = '0;
        end
      end else if (timer == TIMER_LAST) begin
        if (any_free) begin
          timer_n = '0;
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (spawn_sel[i]) begin
              active_n[i] = 1'b1;
              split_n[i]  = 1'b0;
              pos_x_n[i]  = 12'sd256 + $signed({3'b000, random_in[8:0]});
              pos_y_n[i]  = 12'sd704;
              vel_y_n[i]  = 12'sd0 - (12'sd12 + $signed({10'b0, random_in[11:10]}));
              vel_x_n[i]  = $signed({{10{random_in[14]}}, random_in[14:13]});
            end
          end
        end
      end else begin
        timer_n = timer + 1'b1;
      end
    end
  end

  // State registers with synchronous reset to the idle, empty playfield.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state  <= ST_IDLE;
      score  <= '0;
      lives  <= 4'(START_LIVES);
      timer  <= '0;
      active <= '0;
      split  <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
        vel_x[i] <= '0;
        vel_y[i] <= '0;
      end
    end else begin
      state  <= state_n;
      score  <= score_n;
      lives  <= lives_n;
      timer  <= timer_n;
      active <= active_n;
      split  <= split_n;
      pos_x  <= pos_x_n;
      pos_y  <= pos_y_n;
      vel_x  <= vel_x_n;
      vel_y  <= vel_y_n;
    end
  end

  // Pack the slot registers onto the sprite-facing buses.
  always_comb begin
    slot_x_out = '0;
    slot_y_out = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_x_out[11*i +: 11] = pos_x[i][10:0];
      slot_y_out[10*i +: 10] = pos_y[i][9:0];
    end
  end

  assign slot_active_out = active;
  assign slot_split_out  = split;
  assign score_out       = score;
  assign lives_out       = lives;
  assign state_out       = state;

endmodule

// File: tb/tb_veggie_round_ctrl.sv
// tb_veggie_round_ctrl: directed bench for veggie_round_ctrl. A default
// instance covers spawn timing, flight, slicing and retirement; a second
// instance with a short spawn period and two lives fills every slot to
// exercise held spawns, simultaneous exits and game over.
module tb_veggie_round_ctrl;

  localparam int S_STATE  = 0;
  localparam int S_LIVES  = 1;
  localparam int S_SCORE  = 2;
  localparam int S_ACTIVE = 3;
  localparam int S_SPLIT  = 4;
  localparam int S_ANY    = 5;
  localparam int S_X      = 10;
  localparam int S_Y      = 20;
  localparam int FAST     = 100;

  logic clk = 1'b0;
  logic rst;
  logic frame_done, start;
  logic [15:0] random;
  logic [10:0] kx;
  logic [9:0] ky;
  logic [3:0] slot_active, slot_split;
  logic [43:0] slot_x;
  logic [39:0] slot_y;
  logic [15:0] score;
  logic [3:0] lives;
  logic [1:0] state;

  logic f_frame_done, f_start;
  logic [15:0] f_random;
  logic [10:0] f_kx;
  logic [9:0] f_ky;
  logic [3:0] f_slot_active, f_slot_split;
  logic [43:0] f_slot_x;
  logic [39:0] f_slot_y;
  logic [15:0] f_score;
  logic [3:0] f_lives;
  logic [1:0] f_state;

  typedef struct {
    string tag;
    int    sel;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  veggie_round_ctrl dut (
    .clk_in(clk), .rst_in(rst), .frame_done_in(frame_done), .start_in(start),
    .random_in(random), .katana_x(kx), .katana_y(ky),
    .slot_active_out(slot_active), .slot_split_out(slot_split),
    .slot_x_out(slot_x), .slot_y_out(slot_y),
    .score_out(score), .lives_out(lives), .state_out(state)
  );

  veggie_round_ctrl #(.SPAWN_PERIOD(2), .START_LIVES(2)) dut_fast (
    .clk_in(clk), .rst_in(rst), .frame_done_in(f_frame_done), .start_in(f_start),
    .random_in(f_random), .katana_x(f_kx), .katana_y(f_ky),
    .slot_active_out(f_slot_active), .slot_split_out(f_slot_split),
    .slot_x_out(f_slot_x), .slot_y_out(f_slot_y),
    .score_out(f_score), .lives_out(f_lives), .state_out(f_state)
  );

  // Free-running pixel clock.
  always #5 clk = ~clk;

  // Hard stop in case the run never reaches its summary.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int observe(input int sel);
    bit f;
    int b;
    f = (sel >= FAST);
    b = f ? sel - FAST : sel;
    if (b == S_STATE)  return f ? int'(f_state) : int'(state);
    if (b == S_LIVES)  return f ? int'(f_lives) : int'(lives);
    if (b == S_SCORE)  return f ? int'(f_score) : int'(score);
    if (b == S_ACTIVE) return f ? int'(f_slot_active) : int'(slot_active);
    if (b == S_SPLIT)  return f ? int'(f_slot_split) : int'(slot_split);
    if (b == S_ANY)    return f ? int'((|f_slot_x) | (|f_slot_y)) : int'((|slot_x) | (|slot_y));
    if (b >= S_X && b < S_X + 4)
      return f ? int'(f_slot_x[11*(b-S_X) +: 11]) : int'(slot_x[11*(b-S_X) +: 11]);
    if (b >= S_Y && b < S_Y + 4)
      return f ? int'(f_slot_y[10*(b-S_Y) +: 10]) : int'(slot_y[10*(b-S_Y) +: 10]);
    return -1;
  endfunction

  task automatic pushExp(input string tag, input int sel, input int exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    int obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      vectors++;
      assert (obs === e.exp) else begin
        miscompares++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
      end
    end
  endtask

  // One-cycle pulse on either instance; returns 1 time unit after the update edge.
  task automatic applyStimulus(input bit fast, input bit fd, input bit st);
    @(posedge clk);
    #1;
    if (fast) begin f_frame_done = fd; f_start = st; end
    else begin frame_done = fd; start = st; end
    @(posedge clk);
    #1;
    frame_done = 1'b0; start = 1'b0;
    f_frame_done = 1'b0; f_start = 1'b0;
  endtask

  task automatic frames(input bit fast, input int n);
    for (int k = 0; k < n; k++) applyStimulus(fast, 1'b1, 1'b0);
  endtask

  initial begin
    int y_m, vy_m, vy_old, flown;
    bit gone;
    rst = 1'b1; frame_done = 1'b0; start = 1'b0; random = '0; kx = '0; ky = '0;
    f_frame_done = 1'b0; f_start = 1'b0; f_random = '0; f_kx = '0; f_ky = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle for 200 frames without start.
    frames(0, 200);
    pushExp("idle_state", S_STATE, 0);
    pushExp("idle_lives", S_LIVES, 3);
    pushExp("idle_score", S_SCORE, 0);
    pushExp("idle_active", S_ACTIVE, 0);
    pushExp("idle_split", S_SPLIT, 0);
    pushExp("idle_slots", S_ANY, 0);
    pushExp("fast_idle_lives", FAST + S_LIVES, 2);
    checkOutput();

    // Start, then first spawn on the 90th frame.
    random = 16'h0123;
    applyStimulus(0, 1'b0, 1'b1);
    pushExp("start_state", S_STATE, 1);
    pushExp("start_lives", S_LIVES, 3);
    checkOutput();
    frames(0, 89);
    pushExp("pre_spawn_active", S_ACTIVE, 0);
    checkOutput();
    frames(0, 1);
    pushExp("spawn_active", S_ACTIVE, 1);
    pushExp("spawn_x", S_X + 0, 547);
    pushExp("spawn_y", S_Y + 0, 704);
    pushExp("spawn_split", S_SPLIT, 0);
    checkOutput();

    // Unsliced flight to retirement costs one life.
    y_m = 704; vy_m = -12; gone = 1'b0; flown = 0;
    for (int n = 1; n <= 40 && !gone; n++) begin
      applyStimulus(0, 1'b1, 1'b0);
      flown = n;
      vy_old = vy_m; y_m = y_m + vy_m; vy_m = vy_m + 1;
      if (y_m >= 832 && vy_old > 0) begin
        gone = 1'b1;
        pushExp("exit_active", S_ACTIVE, 0);
        pushExp("exit_lives", S_LIVES, 2);
        pushExp("exit_score", S_SCORE, 0);
      end else if (n % 8 == 0) begin
        pushExp("fly_y", S_Y + 0, y_m);
        pushExp("fly_x", S_X + 0, 547);
        pushExp("fly_active", S_ACTIVE, 1);
      end
      checkOutput();
    end

    // Second spawn exactly 90 frames after the first.
    frames(0, 89 - flown);
    pushExp("pre_spawn2_active", S_ACTIVE, 0);
    checkOutput();
    frames(0, 1);
    pushExp("spawn2_active", S_ACTIVE, 1);
    pushExp("spawn2_y", S_Y + 0, 704);
    checkOutput();

    // Katana 65 px away misses; exactly 64 px away on both axes hits.
    kx = 11'd612; ky = 10'd704;
    frames(0, 1);
    pushExp("miss_split", S_SPLIT, 0);
    pushExp("miss_score", S_SCORE, 0);
    pushExp("miss_y", S_Y + 0, 692);
    checkOutput();
    kx = 11'd611; ky = 10'd628;
    frames(0, 1);
    pushExp("hit_split", S_SPLIT, 1);
    pushExp("hit_score", S_SCORE, 1);
    pushExp("hit_y", S_Y + 0, 681);
    checkOutput();
    kx = '0; ky = '0;

    // A sliced veggie leaving the screen costs no life.
    y_m = 681; vy_m = -10; gone = 1'b0;
    for (int n = 1; n <= 40 && !gone; n++) begin
      applyStimulus(0, 1'b1, 1'b0);
      vy_old = vy_m; y_m = y_m + vy_m; vy_m = vy_m + 1;
      if (y_m >= 832 && vy_old > 0) begin
        gone = 1'b1;
        pushExp("slice_exit_active", S_ACTIVE, 0);
        pushExp("slice_exit_split", S_SPLIT, 0);
        pushExp("slice_exit_lives", S_LIVES, 2);
        pushExp("slice_exit_score", S_SCORE, 1);
      end else if (n % 10 == 0) begin
        pushExp("slice_fly_split", S_SPLIT, 1);
        pushExp("slice_fly_y", S_Y + 0, y_m);
      end
      checkOutput();
    end

    // start_in has no effect during PLAY.
    applyStimulus(0, 1'b1, 1'b1);
    pushExp("play_start_state", S_STATE, 1);
    pushExp("play_start_score", S_SCORE, 1);
    checkOutput();

    // Fast instance: fill all four slots with distinct x positions.
    applyStimulus(1, 1'b0, 1'b1);
    f_random = 16'h0000; frames(1, 2);
    pushExp("f_spawn0_active", FAST + S_ACTIVE, 4'b0001);
    pushExp("f_spawn0_x", FAST + S_X + 0, 256);
    checkOutput();
    f_random = 16'h00C8; frames(1, 2);
    pushExp("f_spawn1_x", FAST + S_X + 1, 456);
    f_random = 16'h0590; frames(1, 2);
    pushExp("f_spawn2_x", FAST + S_X + 2, 656);
    f_random = 16'h01F4; frames(1, 2);
    pushExp("f_full_active", FAST + S_ACTIVE, 4'b1111);
    pushExp("f_spawn2_y", FAST + S_Y + 2, 679);
    pushExp("f_spawn3_x", FAST + S_X + 3, 756);
    checkOutput();
    frames(1, 2);
    pushExp("f_held_active", FAST + S_ACTIVE, 4'b1111);
    pushExp("f_slot0_y", FAST + S_Y + 0, 636);
    checkOutput();

    // Slice slot 0 only.
    f_kx = 11'd256; f_ky = 10'd636;
    frames(1, 1);
    pushExp("f_slice_split", FAST + S_SPLIT, 4'b0001);
    pushExp("f_slice_score", FAST + S_SCORE, 1);
    checkOutput();
    f_kx = '0; f_ky = '0; f_random = 16'h0455;

    // Slot 0 frees at frame 35 and is refilled at frame 36, not 35.
    frames(1, 23);
    pushExp("f_f34_active", FAST + S_ACTIVE, 4'b1111);
    checkOutput();
    frames(1, 1);
    pushExp("f_free_active", FAST + S_ACTIVE, 4'b1110);
    pushExp("f_free_lives", FAST + S_LIVES, 2);
    checkOutput();
    frames(1, 1);
    pushExp("f_respawn_active", FAST + S_ACTIVE, 4'b1111);
    pushExp("f_respawn_x", FAST + S_X + 0, 341);
    pushExp("f_respawn_y", FAST + S_Y + 0, 704);
    checkOutput();
    frames(1, 1);
    pushExp("f_loss_active", FAST + S_ACTIVE, 4'b1101);
    pushExp("f_loss_lives", FAST + S_LIVES, 1);
    checkOutput();

    // Two unsplit exits on the same frame with one life left.
    frames(1, 3);
    pushExp("f_f40_lives", FAST + S_LIVES, 1);
    pushExp("f_f40_state", FAST + S_STATE, 1);
    checkOutput();
    frames(1, 1);
    pushExp("f_over_lives", FAST + S_LIVES, 0);
    pushExp("f_over_state", FAST + S_STATE, 2);
    pushExp("f_over_active", FAST + S_ACTIVE, 0);
    pushExp("f_over_slots", FAST + S_ANY, 0);
    pushExp("f_over_score", FAST + S_SCORE, 1);
    checkOutput();
    frames(1, 1);
    pushExp("f_frozen_state", FAST + S_STATE, 2);
    pushExp("f_frozen_score", FAST + S_SCORE, 1);
    checkOutput();

    // Restart from OVER with start coincident with frame_done.
    applyStimulus(1, 1'b1, 1'b1);
    pushExp("f_restart_state", FAST + S_STATE, 1);
    pushExp("f_restart_lives", FAST + S_LIVES, 2);
    pushExp("f_restart_score", FAST + S_SCORE, 0);
    pushExp("f_restart_active", FAST + S_ACTIVE, 0);
    checkOutput();

    // Reset dominates start mid-round.
    @(posedge clk);
    #1 rst = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; start = 1'b0;
    pushExp("rst_state", S_STATE, 0);
    pushExp("rst_lives", S_LIVES, 3);
    pushExp("rst_score", S_SCORE, 0);
    pushExp("rst_slots", S_ANY, 0);
    pushExp("f_rst_state", FAST + S_STATE, 0);
    checkOutput();

    // Start coincident with frame_done in IDLE: no slot work that frame.
    applyStimulus(0, 1'b1, 1'b1);
    pushExp("idle_go_state", S_STATE, 1);
    pushExp("idle_go_active", S_ACTIVE, 0);
    checkOutput();
    frames(0, 89);
    pushExp("idle_go_pre_active", S_ACTIVE, 0);
    checkOutput();
    frames(0, 1);
    pushExp("idle_go_spawn", S_ACTIVE, 1);
    pushExp("idle_go_x", S_X + 0, 547);
    checkOutput();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
